mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single unified memory port between the fetch stage (IF) and the memory stage (MEM).
//   At most one transaction is outstanding at a time.
//   Data accesses have priority, with a bounded-starvation guard for fetch.
//   Drives stallF/stallM into the pipeline stall/flush logic.
//   Discards fetch responses killed by a branch or jump redirect.
// PARAMETERS
//   ADDR_W        64  address width
//   DATA_W        64  memory data width; mask width is DATA_W/8
//   MAX_D_STREAK  2   max consecutive data grants while ifReq is pending (>=1)
// PORTS
//   clk        in   1         clock; all state updates on posedge
//   reset      in   1         synchronous, active-high reset
//   ifReq      in   1         fetch request; held until ifValid or ifKill
//   ifAddr     in   ADDR_W    fetch address (4-byte aligned)
//   ifKill     in   1         pulse: discard the in-flight fetch (redirect)
//   ifValid    out  1         fetch data valid (1 cycle)
//   ifData     out  32        instruction word
//   dReq       in   1         data request; held with fields stable until dValid
//   dWe        in   1         1 = store, 0 = load
//   dAddr      in   ADDR_W    data address
//   dWdata     in   DATA_W    store data
//   dMask      in   DATA_W/8  byte-enable mask
//   dValid     out  1         load data valid / store acknowledge (1 cycle)
//   dRdata     out  DATA_W    load data
//   memReq     out  1         request to memory
//   memWe      out  1         write enable
//   memAddr    out  ADDR_W    address
//   memWdata   out  DATA_W    write data
//   memMask    out  DATA_W/8  byte mask; all ones for fetch
//   memReady   in   1         request accepted when memReq & memReady
//   memRvalid  in   1         response valid (also the write acknowledge)
//   memRdata   in   DATA_W    response data
//   stallF     out  1         = ifReq & ~ifValid
//   stallM     out  1         = dReq & ~dValid
// BEHAVIOUR
//   States: IDLE, ISSUE, WAIT.
//   IDLE: if dReq or ifReq, grant one requester, as follows:
//     - Grant IF when ifReq and (~dReq or streak==MAX_D_STREAK); otherwise grant D.
//     - On grant, register owner plus memAddr/memWe/memWdata/memMask; go to ISSUE.
//     - Fetch grant drives memWe=0 and memMask all ones.
//   ISSUE: memReq=1; fields held stable.
//     - memReady=1 -> WAIT; memReady=0 -> remain in ISSUE.
//     - memRvalid in ISSUE is ignored.
//   WAIT: memReq=0. On memRvalid -> IDLE and deliver the response in the same cycle (combinational):
//     - owner D: dValid=1, dRdata=memRdata.
//     - owner IF: ifValid=~killed. ifData=memRdata[63:32] when ifAddr[2]=1, else memRdata[31:0].
//   Minimum latency: req seen at cycle 0 -> memReq at cycle 1 -> response no earlier than cycle 2.
//     - The next grant is possible at cycle 3.
//   streak (width clog2(MAX_D_STREAK+1)) is updated at each grant:
//     - D grant with ifReq=1: +1, saturating.
//     - IF grant: cleared.
//     - ifReq=0 in any cycle: cleared.
//   killed flag:
//     - Set by ifKill while owner=IF in ISSUE or WAIT.
//     - Cleared on the return to IDLE.
//     - ifKill in the same cycle as memRvalid suppresses ifValid.
//     - ifKill while IDLE, or while owner=D: no effect.
//   A killed fetch still completes on the bus; there is no cancellation toward memory.
//   ifValid and dValid are never both 1. They are 0 in every state except WAIT with memRvalid.
//   memRvalid in IDLE (stray or post-reset) is dropped.
//   Reset:
//     - State IDLE; memReq, memWe, streak and killed cleared.
//     - memAddr, memWdata and memMask set to 0.
//     - ifValid and dValid are 0. stallF and stallM follow their equations.
//   Reset mid-transaction abandons the transaction. The memory is reset on the same reset.
// TESTING
//   1. Fetch only: ifAddr=0x1004, memReady=1, memRvalid at cycle 2, memRdata=0x00000013_00500093.
//      -> ifValid=1, ifData=0x00000013 at cycle 2; stallF=1 in cycles 0-1.
//   2. ifReq and dReq both rise at cycle 0, dAddr=0x2000 load.
//      -> memAddr=0x2000 first; fetch issues after dValid.
//   3. MAX_D_STREAK=2, dReq and ifReq held high, each data op completed on dValid and re-requested.
//      -> grant order D,D,IF,D,D,IF.
//   4. ifKill pulsed in WAIT, then ifAddr changed to 0x3000.
//      -> no ifValid for the old fetch; next memAddr=0x3000; stallF high throughout.
//   5. Store dAddr=0x40, dWdata=0xDEAD, dMask=0x03, memReady low for 3 cycles.
//      -> memReq and all fields stable for 4 cycles; stallM=1 until dValid.
//   6. reset asserted in WAIT, memRvalid the cycle after reset.
//      -> memReq=0, no ifValid/dValid; new request accepted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data access.
// One transaction outstanding; data wins unless fetch has been starved for MAX_D_STREAK grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MAX_D_STREAK = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ifReq,
  input  logic [ADDR_W-1:0]   ifAddr,
  input  logic                ifKill,
  output logic                ifValid,
  output logic [31:0]         ifData,
  input  logic                dReq,
  input  logic                dWe,
  input  logic [ADDR_W-1:0]   dAddr,
  input  logic [DATA_W-1:0]   dWdata,
  input  logic [DATA_W/8-1:0] dMask,
  output logic                dValid,
  output logic [DATA_W-1:0]   dRdata,
  output logic                memReq,
  output logic                memWe,
  output logic [ADDR_W-1:0]   memAddr,
  output logic [DATA_W-1:0]   memWdata,
  output logic [DATA_W/8-1:0] memMask,
  input  logic                memReady,
  input  logic                memRvalid,
  input  logic [DATA_W-1:0]   memRdata,
  output logic                stallF,
  output logic                stallM
);

  // state | meaning
  // IDLE  | no transaction; grant a requester if any
  // ISSUE | memReq driven, waiting for memReady
  // WAIT  | request accepted, waiting for memRvalid
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  state_t        state, stateNext;
  logic          ownerIf;
  logic          killed;
  logic [SW-1:0] streak;
  logic          grant;
  logic          grantIf;
  logic          respDone;

  always_comb begin
    grant    = (state == IDLE) && (dReq || ifReq);
    grantIf  = ifReq && (!dReq || (streak == STREAK_MAX));
    respDone = (state == WAIT) && memRvalid;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grant)     stateNext = ISSUE;
      ISSUE:   if (memReady)  stateNext = WAIT;
      WAIT:    if (memRvalid) stateNext = IDLE;
      default:                stateNext = IDLE;
    endcase
  end

  // Request fields are captured at grant and held until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ownerIf  <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      memMask  <= '0;
    end else if (grant) begin
      ownerIf  <= grantIf;
      memWe    <= grantIf ? 1'b0 : dWe;
      memAddr  <= grantIf ? ifAddr : dAddr;
      memWdata <= grantIf ? '0 : dWdata;
      memMask  <= grantIf ? '1 : dMask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !ifReq) begin
      streak <= '0;
    end else if (grant) begin
      if (grantIf)                   streak <= '0;
      else if (streak != STREAK_MAX) streak <= streak + 1'b1;
    end
  end

  // A killed fetch still runs to completion on the bus; only its delivery is dropped.
  always_ff @(posedge clk) begin
    if (reset || respDone)                        killed <= 1'b0;
    else if (ifKill && ownerIf && state != IDLE)  killed <= 1'b1;
  end

  always_comb begin
    memReq  = (state == ISSUE);
    dValid  = respDone && !ownerIf;
    ifValid = respDone && ownerIf && !killed && !ifKill;
    dRdata  = memRdata;
    ifData  = ifAddr[2] ? memRdata[63:32] : memRdata[31:0];
    stallF  = ifReq && !ifValid;
    stallM  = dReq && !dValid;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after posedge, outputs sampled on negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifReq, ifKill, dReq, dWe, memReady, memRvalid;
  logic [63:0] ifAddr, dAddr, dWdata, memRdata;
  logic [7:0]  dMask;
  logic        ifValid, dValid, memReq, memWe, stallF, stallM;
  logic [31:0] ifData;
  logic [63:0] dRdata, memAddr, memWdata;
  logic [7:0]  memMask;

  int nAssert = 0;
  int nFail   = 0;

  logic [63:0] expAddr [6];
  logic [5:0]  expIsIf;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_D_STREAK(2)) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifKill(ifKill), .ifValid(ifValid), .ifData(ifData),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dMask(dMask),
    .dValid(dValid), .dRdata(dRdata),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memMask(memMask),
    .memReady(memReady), .memRvalid(memRvalid), .memRdata(memRdata),
    .stallF(stallF), .stallM(stallM)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ifReq = 0; ifKill = 0; dReq = 0; dWe = 0; memReady = 0; memRvalid = 0;
    ifAddr = 0; dAddr = 0; dWdata = 0; memRdata = 0; dMask = 0;
    expAddr[0] = 64'h6000; expAddr[1] = 64'h6000; expAddr[2] = 64'h5000;
    expAddr[3] = 64'h6000; expAddr[4] = 64'h6000; expAddr[5] = 64'h5000;
    expIsIf = 6'b100100;

    // reset state
    nc(); nc();
    smp();
    chk("rst_memReq", 64'(memReq), 0);
    chk("rst_memWe", 64'(memWe), 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memMask", 64'(memMask), 0);
    chk("rst_memWdata", memWdata, 0);
    chk("rst_valids", 64'({ifValid, dValid}), 0);
    nc();
    reset = 1'b0;

    // 1: fetch only
    ifReq = 1; ifAddr = 64'h1004; memReady = 1;
    smp(); chk("t1_stallF_c0", 64'(stallF), 1); chk("t1_memReq_c0", 64'(memReq), 0);
    nc();
    smp(); chk("t1_memReq_c1", 64'(memReq), 1); chk("t1_memAddr", memAddr, 64'h1004);
    chk("t1_memWe", 64'(memWe), 0); chk("t1_memMask", 64'(memMask), 64'hFF);
    chk("t1_stallF_c1", 64'(stallF), 1);
    nc();
    memRvalid = 1; memRdata = 64'h00000013_00500093;
    smp(); chk("t1_ifValid", 64'(ifValid), 1); chk("t1_ifData", 64'(ifData), 64'h13);
    chk("t1_stallF_c2", 64'(stallF), 0); chk("t1_memReq_c2", 64'(memReq), 0);
    chk("t1_dValid", 64'(dValid), 0);
    nc();
    ifReq = 0; memRvalid = 0;
    smp(); chk("t1_ifValid_c3", 64'(ifValid), 0);
    nc();

    // 2: simultaneous requests, data first
    ifReq = 1; ifAddr = 64'h1008; dReq = 1; dWe = 0; dAddr = 64'h2000; dMask = 8'hFF;
    nc();
    smp(); chk("t2_memAddr_d", memAddr, 64'h2000); chk("t2_memReq", 64'(memReq), 1);
    nc();
    memRvalid = 1; memRdata = 64'h11223344_55667788;
    smp(); chk("t2_dValid", 64'(dValid), 1); chk("t2_dRdata", dRdata, 64'h11223344_55667788);
    chk("t2_ifValid", 64'(ifValid), 0); chk("t2_stallM", 64'(stallM), 0); chk("t2_stallF", 64'(stallF), 1);
    nc();
    dReq = 0; memRvalid = 0;
    smp(); chk("t2_idle_memReq", 64'(memReq), 0);
    nc();
    smp(); chk("t2_memAddr_if", memAddr, 64'h1008); chk("t2_memMask_if", 64'(memMask), 64'hFF);
    nc();
    memRvalid = 1; memRdata = 64'hAAAAAAAA_BBBBBBBB;
    smp(); chk("t2_ifValid_done", 64'(ifValid), 1); chk("t2_ifData", 64'(ifData), 64'hBBBBBBBB);
    nc();
    ifReq = 0; memRvalid = 0;
    nc();

    // 3: starvation guard, order D,D,IF,D,D,IF
    ifReq = 1; ifAddr = 64'h5000; dReq = 1; dWe = 0; dAddr = 64'h6000;
    for (int i = 0; i < 6; i++) begin
      nc();
      smp(); chk($sformatf("t3_addr%0d", i), memAddr, expAddr[i]);
      nc();
      memRvalid = 1;
      smp(); chk($sformatf("t3_ifValid%0d", i), 64'(ifValid), 64'(expIsIf[i]));
      chk($sformatf("t3_dValid%0d", i), 64'(dValid), 64'(!expIsIf[i]));
      nc();
      memRvalid = 0;
    end
    ifReq = 0; dReq = 0;
    nc();

    // 4: kill in WAIT, redirect to 0x3000
    ifReq = 1; ifAddr = 64'h1000; memReady = 1;
    nc(); nc();
    ifKill = 1;
    smp(); chk("t4_stallF_kill", 64'(stallF), 1); chk("t4_ifValid_kill", 64'(ifValid), 0);
    nc();
    ifKill = 0; ifAddr = 64'h3000; memRvalid = 1; memRdata = 64'h12345678_9ABCDEF0;
    smp(); chk("t4_ifValid_old", 64'(ifValid), 0); chk("t4_stallF_old", 64'(stallF), 1);
    nc();
    memRvalid = 0;
    smp(); chk("t4_stallF_idle", 64'(stallF), 1);
    nc();
    smp(); chk("t4_memAddr_new", memAddr, 64'h3000); chk("t4_memReq_new", 64'(memReq), 1);
    nc();
    memRvalid = 1;
    smp(); chk("t4_ifValid_new", 64'(ifValid), 1); chk("t4_ifData_new", 64'(ifData), 64'h9ABCDEF0);
    nc();
    memRvalid = 0;
    // kill coincident with the response suppresses delivery
    nc(); nc();
    ifKill = 1; memRvalid = 1;
    smp(); chk("t4_ifValid_samecyc", 64'(ifValid), 0);
    nc();
    ifKill = 0; memRvalid = 0; ifReq = 0;
    nc();

    // 5: store held by memReady low for 3 cycles
    dReq = 1; dWe = 1; dAddr = 64'h40; dWdata = 64'hDEAD; dMask = 8'h03; memReady = 0;
    nc();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) memReady = 1;
      memRvalid = (c == 1);
      smp();
      chk($sformatf("t5_memReq%0d", c), 64'(memReq), 1);
      chk($sformatf("t5_fields%0d", c), {memAddr[15:0], memWdata[15:0], 8'(memMask), 7'd0, memWe, 16'd0},
          {16'h0040, 16'hDEAD, 8'h03, 7'd0, 1'b1, 16'd0});
      chk($sformatf("t5_stallM%0d", c), 64'({stallM, dValid}), 64'b10);
      nc();
    end
    memReady = 0; memRvalid = 1;
    smp(); chk("t5_dValid", 64'(dValid), 1); chk("t5_stallM_done", 64'(stallM), 0);
    chk("t5_memReq_wait", 64'(memReq), 0);
    nc();
    dReq = 0; dWe = 0; memRvalid = 0; memReady = 1;
    nc();

    // 6: reset during WAIT, stray response after reset
    ifReq = 1; ifAddr = 64'h7000;
    nc(); nc();
    reset = 1;
    nc();
    reset = 0; ifReq = 0; memRvalid = 1;
    smp(); chk("t6_memReq", 64'(memReq), 0); chk("t6_valids", 64'({ifValid, dValid}), 0);
    chk("t6_memAddr", memAddr, 0);
    nc();
    memRvalid = 0; dReq = 1; dWe = 0; dAddr = 64'h88; dMask = 8'hFF;
    smp(); chk("t6_idle_memReq", 64'(memReq), 0);
    nc();
    smp(); chk("t6_memAddr_new", memAddr, 64'h88); chk("t6_memReq_new", 64'(memReq), 1);
    nc();
    memRvalid = 1; memRdata = 64'h55;
    smp(); chk("t6_dValid", 64'(dValid), 1); chk("t6_dRdata", dRdata, 64'h55);
    nc();
    dReq = 0; memRvalid = 0;
    nc();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
